// File: rtl/rege_pkg.sv
// Shared pipeline package: default datapath widths and the decoded-op encoding.
// Imported by the execute-stage register slice, its interface and its latency counter.
package rege_pkg;

  localparam int unsigned PIPE_WIDTH      = 64;  // datapath and PC width
  localparam int unsigned PIPE_INSTR_SIZE = 32;  // instruction width
  localparam int unsigned PIPE_OP_SIZE    = 12;  // decoded-op width
  localparam int unsigned PIPE_GPR_SIZE   = 5;   // register-index width
  localparam int unsigned PIPE_LAT_SIZE   = 6;   // multi-cycle latency field width

  // One-hot decoded op classes carried through the pipeline.
  typedef enum logic [PIPE_OP_SIZE-1:0] {
    OP_ALU    = 12'h001,
    OP_MUL    = 12'h002,
    OP_DIV    = 12'h004,
    OP_LOAD   = 12'h008,
    OP_STORE  = 12'h010,
    OP_BRANCH = 12'h020
  } op_e;

endpackage

// File: rtl/rege_if.sv
// Decode -> execute -> memory handshake and payload bundle for the execute stage.
//   slave  : the execute stage (consumes regD_*, regM_allow_in, flush; drives regE_*)
//   master : the surrounding pipeline / bench (drives regD_*, regM_allow_in, flush)
interface rege_if
  import rege_pkg::*;
#(
  parameter int unsigned WIDTH      = PIPE_WIDTH,
  parameter int unsigned INSTR_SIZE = PIPE_INSTR_SIZE,
  parameter int unsigned OP_SIZE    = PIPE_OP_SIZE,
  parameter int unsigned GPR_SIZE   = PIPE_GPR_SIZE,
  parameter int unsigned LAT_SIZE   = PIPE_LAT_SIZE
);

  logic                  regD_to_regE_valid;
  logic                  regM_allow_in;
  logic                  flush;
  logic [WIDTH-1:0]      regD_pc;
  logic [INSTR_SIZE-1:0] regD_instr;
  logic [OP_SIZE-1:0]    regD_op;
  logic [GPR_SIZE-1:0]   regD_rd;
  logic [WIDTH-1:0]      regD_src1;
  logic [WIDTH-1:0]      regD_src2;
  logic                  regD_multi;
  logic [LAT_SIZE-1:0]   regD_lat;

  logic                  regE_allow_in;
  logic                  regE_to_regM_valid;
  logic [WIDTH-1:0]      regE_pc;
  logic [INSTR_SIZE-1:0] regE_instr;
  logic [OP_SIZE-1:0]    regE_op;
  logic [GPR_SIZE-1:0]   regE_rd;
  logic [WIDTH-1:0]      regE_src1;
  logic [WIDTH-1:0]      regE_src2;
  logic                  regE_busy;

  modport slave (
    input  regD_to_regE_valid, regM_allow_in, flush,
    input  regD_pc, regD_instr, regD_op, regD_rd, regD_src1, regD_src2,
    input  regD_multi, regD_lat,
    output regE_allow_in, regE_to_regM_valid,
    output regE_pc, regE_instr, regE_op, regE_rd, regE_src1, regE_src2,
    output regE_busy
  );

  modport master (
    output regD_to_regE_valid, regM_allow_in, flush,
    output regD_pc, regD_instr, regD_op, regD_rd, regD_src1, regD_src2,
    output regD_multi, regD_lat,
    input  regE_allow_in, regE_to_regM_valid,
    input  regE_pc, regE_instr, regE_op, regE_rd, regE_src1, regE_src2,
    input  regE_busy
  );

endinterface

// File: rtl/regE_lat_cnt.sv
// Execute-stage latency counter: counts remaining extra execute cycles of the
// op held in the stage.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count (flush)
//   load     : load loadVal (op accepted)
//   loadVal  : extra-cycle count of the accepted op
//   dec      : stage holds a valid op; count down while nonzero
//   zero     : count is zero (op ready to leave)
module regE_lat_cnt
  import rege_pkg::*;
#(
  parameter int unsigned LAT_SIZE = PIPE_LAT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [LAT_SIZE-1:0] loadVal,
  input  logic                dec,
  output logic                zero
);

  logic [LAT_SIZE-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/rege.sv
// Execute-stage pipeline register (regE). Holds one op between decode and
// memory, stretching multi-cycle ops by their latency field before offering
// them downstream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rege_if.slave -- regD_* payload/valid in, regM_allow_in and
//              flush in; regE_* payload, regE_allow_in, regE_to_regM_valid,
//              regE_busy out
module rege
  import rege_pkg::*;
#(
  parameter int unsigned WIDTH      = PIPE_WIDTH,
  parameter int unsigned INSTR_SIZE = PIPE_INSTR_SIZE,
  parameter int unsigned OP_SIZE    = PIPE_OP_SIZE,
  parameter int unsigned GPR_SIZE   = PIPE_GPR_SIZE,
  parameter int unsigned LAT_SIZE   = PIPE_LAT_SIZE
) (
  input  logic   clk,
  input  logic   rst,
  rege_if.slave  bus
);

  logic                  regEValid;
  logic                  readyGo;
  logic                  allowIn;
  logic                  accept;
  logic                  take;
  logic [LAT_SIZE-1:0]   latLoad;

  logic [WIDTH-1:0]      pcQ;
  logic [INSTR_SIZE-1:0] instrQ;
  logic [OP_SIZE-1:0]    opQ;
  logic [GPR_SIZE-1:0]   rdQ;
  logic [WIDTH-1:0]      src1Q;
  logic [WIDTH-1:0]      src2Q;

  always_comb begin
    allowIn = !regEValid || (readyGo && bus.regM_allow_in);
    accept  = bus.regD_to_regE_valid && allowIn;
    // A flush overrides a concurrent accept, so nothing is captured.
    take    = accept && !bus.flush;
    latLoad = bus.regD_multi ? bus.regD_lat : '0;
  end

  regE_lat_cnt #(
    .LAT_SIZE (LAT_SIZE)
  ) u_latCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.flush),
    .load    (take),
    .loadVal (latLoad),
    .dec     (regEValid),
    .zero    (readyGo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      regEValid <= 1'b0;
    end else if (bus.flush) begin
      regEValid <= 1'b0;
    end else if (allowIn) begin
      regEValid <= bus.regD_to_regE_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ    <= '0;
      instrQ <= '0;
      opQ    <= '0;
      rdQ    <= '0;
      src1Q  <= '0;
      src2Q  <= '0;
    end else if (take) begin
      pcQ    <= bus.regD_pc;
      instrQ <= bus.regD_instr;
      opQ    <= bus.regD_op;
      rdQ    <= bus.regD_rd;
      src1Q  <= bus.regD_src1;
      src2Q  <= bus.regD_src2;
    end
  end

  always_comb begin
    bus.regE_allow_in      = allowIn;
    bus.regE_to_regM_valid = regEValid && readyGo;
    bus.regE_busy          = regEValid && !readyGo;
    bus.regE_pc            = pcQ;
    bus.regE_instr         = instrQ;
    bus.regE_op            = opQ;
    bus.regE_rd            = rdQ;
    bus.regE_src1          = src1Q;
    bus.regE_src2          = src2Q;
  end

endmodule

// File: tb/tb_rege.sv
module tb_rege;
  import rege_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rege_if bus ();

  rege dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the stage is a single slot holding an op plus the
  // absolute cycle number from which it may leave.
  bit          mValid = 1'b0;
  int          mReadyAt = 0;
  int          cyc = 0;
  logic [63:0] mPc = '0;
  logic [31:0] mInstr = '0;
  logic [11:0] mOp = '0;
  logic [4:0]  mRd = '0;
  logic [63:0] mSrc1 = '0;
  logic [63:0] mSrc2 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [11:0] randOp();
    case ($urandom_range(0, 5))
      0: return OP_ALU;
      1: return OP_MUL;
      2: return OP_DIV;
      3: return OP_LOAD;
      4: return OP_STORE;
      default: return OP_BRANCH;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, clock,
  // then advance the model with the same inputs.
  task automatic step(input bit dv, input bit mAllow, input bit fl, input bit r,
                      input bit multi, input int lat);
    bit expOffer, expBusy, expAllow;
    bus.regD_to_regE_valid = dv;
    bus.regM_allow_in      = mAllow;
    bus.flush              = fl;
    rst                    = r;
    bus.regD_multi         = multi;
    bus.regD_lat           = 6'(lat);
    bus.regD_pc            = {$urandom, $urandom};
    bus.regD_instr         = $urandom;
    bus.regD_op            = randOp();
    bus.regD_rd            = 5'($urandom);
    bus.regD_src1          = {$urandom, $urandom};
    bus.regD_src2          = {$urandom, $urandom};
    #1;
    expOffer = mValid && (cyc >= mReadyAt);
    expBusy  = mValid && (cyc < mReadyAt);
    expAllow = !mValid || (expOffer && mAllow);
    chk("allow_in", 64'(bus.regE_allow_in), 64'(expAllow));
    chk("to_regM_valid", 64'(bus.regE_to_regM_valid), 64'(expOffer));
    chk("busy", 64'(bus.regE_busy), 64'(expBusy));
    chk("pc", bus.regE_pc, mPc);
    chk("instr", 64'(bus.regE_instr), 64'(mInstr));
    chk("op", 64'(bus.regE_op), 64'(mOp));
    chk("rd", 64'(bus.regE_rd), 64'(mRd));
    chk("src1", bus.regE_src1, mSrc1);
    chk("src2", bus.regE_src2, mSrc2);
    @(posedge clk);
    if (r) begin
      mValid = 1'b0;
      mPc = '0; mInstr = '0; mOp = '0; mRd = '0; mSrc1 = '0; mSrc2 = '0;
    end else if (fl) begin
      mValid = 1'b0;
    end else if (expAllow) begin
      mValid = dv;
      if (dv) begin
        mReadyAt = cyc + 1 + (multi ? lat : 0);
        mPc = bus.regD_pc; mInstr = bus.regD_instr; mOp = bus.regD_op;
        mRd = bus.regD_rd; mSrc1 = bus.regD_src1; mSrc2 = bus.regD_src2;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.regD_to_regE_valid = 1'b0;
    bus.regM_allow_in = 1'b0;
    bus.flush = 1'b0;
    bus.regD_multi = 1'b0;
    bus.regD_lat = '0;
    bus.regD_pc = '0; bus.regD_instr = '0; bus.regD_op = '0; bus.regD_rd = '0;
    bus.regD_src1 = '0; bus.regD_src2 = '0;
    @(posedge clk);
    @(negedge clk);
    // Reset with a valid request present, then confirm post-reset state.
    step(1, 1, 0, 1, 1, 4);
    step(1, 1, 0, 1, 0, 0);
    chk("reset_allow_in", 64'(bus.regE_allow_in), 64'd1);
    chk("reset_offer", 64'(bus.regE_to_regM_valid), 64'd0);
    chk("reset_busy", 64'(bus.regE_busy), 64'd0);

    // Back-to-back single-cycle ops with the memory stage always ready.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Multi-cycle op with latency 3, then idle while it counts down.
    step(1, 1, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    chk("lat3_offer_cycle4", 64'(bus.regE_to_regM_valid), 64'd1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Single op held by a 5-cycle downstream stall, then released.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Flush during a latency-5 op with a new op arriving in the same cycle.
    step(1, 1, 0, 0, 1, 5);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("flush_empty_offer", 64'(bus.regE_to_regM_valid), 64'd0);
    chk("flush_empty_busy", 64'(bus.regE_busy), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);

    // Reset mid-count with a valid request present.
    step(1, 1, 0, 0, 1, 5);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 2);
    chk("rst_mid_allow_in", 64'(bus.regE_allow_in), 64'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);

    // Multi flag with zero latency behaves as a single-cycle op.
    step(1, 1, 0, 0, 1, 0);
    chk("lat0_offer_next", 64'(bus.regE_to_regM_valid), 64'd1);
    step(1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 3, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rege.md
REGE -- requirements
Module: regE

Interface
REQ-001 SHALL have parameter WIDTH, default 64: datapath and PC width.
REQ-002 SHALL have parameter INSTR_SIZE, default 32: instruction width.
REQ-003 SHALL have parameter OP_SIZE, default 12: decoded-op width.
REQ-004 SHALL have parameter GPR_SIZE, default 5: register-index width.
REQ-005 SHALL have parameter LAT_SIZE, default 6: multi-cycle latency field width.
REQ-006 SHALL have port `clk`, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port `rst`, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port `regD_to_regE_valid`, input, 1: upstream (decode) payload valid.
REQ-009 SHALL have port `regM_allow_in`, input, 1: downstream memory stage can accept.
REQ-010 SHALL have port `flush`, input, 1: kill the stage contents.
REQ-011 SHALL have port `regD_pc`, input, WIDTH: PC.
REQ-012 SHALL have port `regD_instr`, input, INSTR_SIZE: instruction.
REQ-013 SHALL have port `regD_op`, input, OP_SIZE: decoded op.
REQ-014 SHALL have port `regD_rd`, input, GPR_SIZE: destination register.
REQ-015 SHALL have ports `regD_src1` and `regD_src2`, input, WIDTH each: operands.
REQ-016 SHALL have port `regD_multi`, input, 1: op is multi-cycle.
REQ-017 SHALL have port `regD_lat`, input, LAT_SIZE: extra execute cycles when `regD_multi`=1.
REQ-018 SHALL have port `regE_allow_in`, output, 1: this stage accepts this cycle.
REQ-019 SHALL have port `regE_to_regM_valid`, output, 1: payload offered to the memory stage.
REQ-020 SHALL have ports `regE_pc`, `regE_instr`, `regE_op`, `regE_rd`, `regE_src1`, `regE_src2`, outputs, each the same width as its regD_ counterpart: registered payload.
REQ-021 SHALL have port `regE_busy`, output, 1: stage valid and latency counter nonzero.

Function
REQ-022 SHALL drive `regE_allow_in` = !regE_valid || (ready_go && `regM_allow_in`), combinationally.
REQ-023 SHALL define ready_go = (cnt == 0) and drive `regE_to_regM_valid` = regE_valid && ready_go.
REQ-024 SHALL treat an accept as `regD_to_regE_valid` && `regE_allow_in` at a clock edge.
REQ-025 On accept, SHALL latch all regD_ payload fields and load cnt with `regD_lat` if `regD_multi`=1, else with 0.
REQ-026 When `regE_allow_in`=1, SHALL load regE_valid with `regD_to_regE_valid`; otherwise SHALL hold regE_valid.
REQ-027 SHALL hold the payload and regE_valid unchanged while stalled (valid && !(ready_go && `regM_allow_in`)).
REQ-028 SHALL decrement cnt by 1 per cycle while regE_valid=1 and cnt!=0, independent of `regM_allow_in`.
REQ-029 Latency: single-cycle op accepted at edge t SHALL present `regE_to_regM_valid`=1 in cycle t+1.
REQ-030 Latency: multi op with `regD_lat`=N SHALL present `regE_to_regM_valid`=1 in cycle t+1+N.
REQ-031 SHALL treat `regD_multi`=1 with `regD_lat`=0 exactly as a single-cycle op.
REQ-032 Simultaneous drain and accept in one cycle SHALL replace the payload with no bubble (throughput 1 per cycle).
REQ-033 `flush`=1 SHALL clear regE_valid and cnt at the next edge, overriding a concurrent accept.
REQ-034 A flush mid-count SHALL abort the multi-cycle op with no output.
REQ-035 SHALL keep `regE_busy`=0 whenever `flush` clears the stage.

Reset
REQ-036 `rst`=1 at an edge SHALL clear regE_valid, cnt and all payload outputs to 0.
REQ-037 SHALL give `rst` priority over `flush` and accept.
REQ-038 After reset, SHALL drive `regE_allow_in`=1, `regE_to_regM_valid`=0 and `regE_busy`=0.
REQ-039 Reset asserted mid-count SHALL discard the op.

Structure
REQ-040 WIDTH, INSTR_SIZE, OP_SIZE, GPR_SIZE and LAT_SIZE defaults SHALL live in the shared pipeline package, together with the op encoding constants.
REQ-041 SHALL implement one sub-module, `regE_lat_cnt`, holding cnt: load, decrement, clear, zero flag.
REQ-042 SHALL keep all handshake logic in regE itself.

Verification
REQ-043 Back-to-back single ops, regM_allow_in=1 -> one offer per cycle, payload order preserved, regE_allow_in stays 1.
REQ-044 Multi op lat=3 accepted at edge 0 -> busy in cycles 1-3, regE_to_regM_valid=1 in cycle 4, regE_allow_in=0 in cycles 1-3.
REQ-045 Single op, regM_allow_in=0 for 5 cycles -> valid held, payload stable, regE_allow_in=0, then drains one cycle after release.
REQ-046 Flush at cycle 2 of a lat=5 op, with a new regD valid in the same cycle -> stage empty next cycle, no offer, new op dropped.
REQ-047 rst asserted mid-count with regD valid -> all outputs 0 next cycle, regE_allow_in=1.
REQ-048 regD_multi=1 with regD_lat=0 -> offered in cycle t+1, identical to a single-cycle op.
